// File: rtl/sdram_pkg.sv
// Shared constants for the SDRAM front-end and controller.
// FSM encodings, port ids and default bus widths.
package sdram_pkg;

    localparam int ADDR_W_DEF = 24;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/sdram_req_latch.sv
// Single-entry request holder for one arbiter port.
// Captures addr/d/we on an accepted start; clears when the grant completes.
module sdram_req_latch
    import sdram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d,
    input  logic              we,
    input  logic              clear,
    output logic              pending,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_d,
    output logic              req_we
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending  <= 1'b0;
            req_addr <= '0;
            req_d    <= '0;
            req_we   <= 1'b0;
        end else if (clear) begin
            pending <= 1'b0;
        end else if (start && !pending) begin
            pending  <= 1'b1;
            req_addr <= addr;
            req_d    <= d;
            req_we   <= we;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-master front-end for the SDRAM controller.
// Serialises port A/B requests and re-issues starts swallowed by refresh.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_d,
    input  logic              a_we,
    input  logic              a_start,
    output logic [DATA_W-1:0] a_q,
    output logic              a_done,
    output logic              a_busy,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_d,
    input  logic              b_we,
    input  logic              b_start,
    output logic [DATA_W-1:0] b_q,
    output logic              b_done,
    output logic              b_busy,
    output logic [ADDR_W-1:0] ctrl_addr,
    output logic [DATA_W-1:0] ctrl_d,
    output logic              ctrl_we,
    output logic              ctrl_start,
    input  logic              ctrl_busy,
    input  logic [DATA_W-1:0] ctrl_q,
    input  logic              ctrl_q_ready,
    input  logic              ctrl_init_done
);

    logic [1:0]        state;
    logic              grant;
    logic              last_grant;
    logic              win_b;
    logic              a_pend, b_pend;
    logic              a_clr, b_clr;
    logic [ADDR_W-1:0] a_raddr, b_raddr;
    logic [DATA_W-1:0] a_rd, b_rd;
    logic              a_rwe, b_rwe;

    // Pending clears as the data is captured, so busy is already low on done.
    assign a_clr = (state == ST_WAIT) && ctrl_q_ready && (grant == PORT_A);
    assign b_clr = (state == ST_WAIT) && ctrl_q_ready && (grant == PORT_B);

    sdram_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lat_a (
        .clk      (clk),
        .reset    (reset),
        .start    (a_start),
        .addr     (a_addr),
        .d        (a_d),
        .we       (a_we),
        .clear    (a_clr),
        .pending  (a_pend),
        .req_addr (a_raddr),
        .req_d    (a_rd),
        .req_we   (a_rwe)
    );

    sdram_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lat_b (
        .clk      (clk),
        .reset    (reset),
        .start    (b_start),
        .addr     (b_addr),
        .d        (b_d),
        .we       (b_we),
        .clear    (b_clr),
        .pending  (b_pend),
        .req_addr (b_raddr),
        .req_d    (b_rd),
        .req_we   (b_rwe)
    );

    assign a_busy     = a_pend;
    assign b_busy     = b_pend;
    assign ctrl_start = (state == ST_ISSUE);
    assign a_done     = (state == ST_RESP) && (grant == PORT_A);
    assign b_done     = (state == ST_RESP) && (grant == PORT_B);

    always_comb begin
        win_b = b_pend;
        if (a_pend && b_pend)
            win_b = (FIXED_PRIO != 0) ? 1'b0 : (last_grant == PORT_A);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            grant      <= PORT_A;
            last_grant <= PORT_B;
            ctrl_addr  <= '0;
            ctrl_d     <= '0;
            ctrl_we    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if ((a_pend || b_pend) && ctrl_init_done && !ctrl_busy) begin
                        grant      <= win_b;
                        last_grant <= win_b;
                        ctrl_addr  <= win_b ? b_raddr : a_raddr;
                        ctrl_d     <= win_b ? b_rd : a_rd;
                        ctrl_we    <= win_b ? b_rwe : a_rwe;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (ctrl_busy)
                        state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ctrl_q_ready) begin
                        if (!ctrl_we && grant == PORT_A)
                            a_q <= ctrl_q;
                        if (!ctrl_we && grant == PORT_B)
                            b_q <= ctrl_q;
                        state <= ST_RESP;
                    end else if (!ctrl_busy) begin
                        // Start was eaten by a refresh: retry from IDLE.
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small behavioural controller.
// The controller model can swallow starts to mimic auto-refresh.
module tb_sdram_arbiter;

    localparam int AW = 24;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_d = '0, b_d = '0;
    logic          a_we = 1'b0, b_we = 1'b0;
    logic          a_start = 1'b0, b_start = 1'b0;
    logic [DW-1:0] a_q, b_q;
    logic          a_done, b_done, a_busy, b_busy;
    logic [AW-1:0] ctrl_addr;
    logic [DW-1:0] ctrl_d;
    logic          ctrl_we, ctrl_start;
    logic          ctrl_busy = 1'b0;
    logic [DW-1:0] ctrl_q = '0;
    logic          ctrl_q_ready = 1'b0;
    logic          ctrl_init_done = 1'b1;

    int total = 0;
    int bad = 0;

    int            mdl_lat = 4;
    logic [DW-1:0] mdl_rdata = '0;
    int            steal_upto = 0;
    int            n_steal = 0;
    int            n_issue = 0;
    int            cnt = 0;
    logic          stolen = 1'b0;
    logic          cur_we = 1'b0;
    logic [AW-1:0] iss_addr [64];
    logic [DW-1:0] iss_d [64];
    int            cyc = 0;
    int            a_cnt = 0, b_cnt = 0;
    int            a_last = 0, b_last = 0;

    always #5 clk = ~clk;

    sdram_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .a_addr         (a_addr),
        .a_d            (a_d),
        .a_we           (a_we),
        .a_start        (a_start),
        .a_q            (a_q),
        .a_done         (a_done),
        .a_busy         (a_busy),
        .b_addr         (b_addr),
        .b_d            (b_d),
        .b_we           (b_we),
        .b_start        (b_start),
        .b_q            (b_q),
        .b_done         (b_done),
        .b_busy         (b_busy),
        .ctrl_addr      (ctrl_addr),
        .ctrl_d         (ctrl_d),
        .ctrl_we        (ctrl_we),
        .ctrl_start     (ctrl_start),
        .ctrl_busy      (ctrl_busy),
        .ctrl_q         (ctrl_q),
        .ctrl_q_ready   (ctrl_q_ready),
        .ctrl_init_done (ctrl_init_done)
    );

    // Controller model: ignores arbiter reset, like the real controller.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        ctrl_q_ready <= 1'b0;
        if (!ctrl_busy) begin
            if (ctrl_start) begin
                ctrl_busy <= 1'b1;
                stolen <= (n_steal < steal_upto);
                if (n_steal < steal_upto) begin
                    n_steal <= n_steal + 1;
                    cnt <= 7;
                end else begin
                    cnt <= mdl_lat;
                end
                iss_addr[n_issue % 64] <= ctrl_addr;
                iss_d[n_issue % 64] <= ctrl_d;
                n_issue <= n_issue + 1;
                cur_we <= ctrl_we;
            end
        end else begin
            if (cnt == 1) begin
                ctrl_busy <= 1'b0;
                if (!stolen) begin
                    ctrl_q_ready <= 1'b1;
                    ctrl_q <= cur_we ? '0 : mdl_rdata;
                end
            end
            cnt <= cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (a_done) begin
            a_cnt <= a_cnt + 1;
            a_last <= cyc;
        end
        if (b_done) begin
            b_cnt <= b_cnt + 1;
            b_last <= cyc;
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b0;
        a_start = 1'b0;
        b_start = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        tick;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while ((a_busy || b_busy || ctrl_busy || ctrl_start) && n < lim) begin
            tick;
            n++;
        end
        total++;
        if (n >= lim) begin
            bad++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", lim);
        end
        tick;
        tick;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick;
        tick;
        total++;
        if ({ctrl_start, ctrl_we, a_done, b_done, a_busy, b_busy} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b required 000000",
                     {ctrl_start, ctrl_we, a_done, b_done, a_busy, b_busy});
        end
        total++;
        if (ctrl_addr !== '0) begin
            bad++;
            $display("FAIL reset_ctrl_addr: got %h required 0", ctrl_addr);
        end
        total++;
        if (ctrl_d !== '0) begin
            bad++;
            $display("FAIL reset_ctrl_d: got %h required 0", ctrl_d);
        end
        total++;
        if (a_q !== '0) begin
            bad++;
            $display("FAIL reset_a_q: got %h required 0", a_q);
        end
        total++;
        if (b_q !== '0) begin
            bad++;
            $display("FAIL reset_b_q: got %h required 0", b_q);
        end
        reset = 1'b1;
        tick;
    endtask

    task automatic test_single_read;
        int a0, b0;
        do_reset;
        a0 = a_cnt;
        b0 = b_cnt;
        mdl_lat = 4;
        mdl_rdata = 32'hDEADBEEF;
        a_addr = 24'h000123;
        a_we = 1'b0;
        a_d = '0;
        a_start = 1'b1;
        tick;
        a_start = 1'b0;
        total++;
        if ({a_busy, ctrl_start} !== 2'b10) begin
            bad++;
            $display("FAIL rd_cycle1: busy,start got %b required 10", {a_busy, ctrl_start});
        end
        tick;
        total++;
        if (ctrl_start !== 1'b1) begin
            bad++;
            $display("FAIL rd_cycle2_start: got %b required 1", ctrl_start);
        end
        total++;
        if ({ctrl_addr, ctrl_we} !== {24'h000123, 1'b0}) begin
            bad++;
            $display("FAIL rd_ctrl_addr: got %h/%b required 000123/0", ctrl_addr, ctrl_we);
        end
        wait_idle(50);
        total++;
        if (a_q !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL rd_a_q: got %h required deadbeef", a_q);
        end
        total++;
        if (a_cnt - a0 != 1) begin
            bad++;
            $display("FAIL rd_a_done: got %0d pulses required 1", a_cnt - a0);
        end
        total++;
        if (b_cnt - b0 != 0) begin
            bad++;
            $display("FAIL rd_b_done: got %0d pulses required 0", b_cnt - b0);
        end
    endtask

    task automatic test_rr_writes;
        int a0, b0, i0;
        do_reset;
        a0 = a_cnt;
        b0 = b_cnt;
        i0 = n_issue;
        mdl_lat = 3;
        a_addr = 24'h000010;
        a_d = 32'h11111111;
        a_we = 1'b1;
        b_addr = 24'h000020;
        b_d = 32'h22222222;
        b_we = 1'b1;
        a_start = 1'b1;
        b_start = 1'b1;
        tick;
        a_start = 1'b0;
        b_start = 1'b0;
        wait_idle(100);
        total++;
        if (n_issue - i0 != 2) begin
            bad++;
            $display("FAIL rr_issue_count: got %0d required 2", n_issue - i0);
        end
        total++;
        if (iss_d[i0 % 64] !== 32'h11111111) begin
            bad++;
            $display("FAIL rr_first_d: got %h required 11111111", iss_d[i0 % 64]);
        end
        total++;
        if (iss_d[(i0 + 1) % 64] !== 32'h22222222) begin
            bad++;
            $display("FAIL rr_second_d: got %h required 22222222", iss_d[(i0 + 1) % 64]);
        end
        total++;
        if (!(a_cnt - a0 == 1 && b_cnt - b0 == 1 && a_last < b_last)) begin
            bad++;
            $display("FAIL rr_done_order: a=%0d@%0d b=%0d@%0d required one each, a first",
                     a_cnt - a0, a_last, b_cnt - b0, b_last);
        end
    endtask

    task automatic test_refresh_steal;
        int b0, i0, n;
        do_reset;
        b0 = b_cnt;
        i0 = n_issue;
        steal_upto = n_steal + 1;
        mdl_lat = 3;
        mdl_rdata = 32'hCAFEF00D;
        b_addr = 24'h000456;
        b_we = 1'b0;
        b_start = 1'b1;
        tick;
        b_start = 1'b0;
        n = 0;
        while (n_issue - i0 < 2 && n < 40) begin
            tick;
            n++;
        end
        total++;
        if ({b_q, b_cnt - b0 == 0} !== {32'h0, 1'b1}) begin
            bad++;
            $display("FAIL steal_early: b_q=%h dones=%0d required 0 and 0", b_q, b_cnt - b0);
        end
        wait_idle(60);
        total++;
        if (iss_addr[i0 % 64] !== 24'h000456 || iss_addr[(i0 + 1) % 64] !== 24'h000456) begin
            bad++;
            $display("FAIL steal_reissue: got %h,%h required 000456 twice",
                     iss_addr[i0 % 64], iss_addr[(i0 + 1) % 64]);
        end
        total++;
        if (b_q !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL steal_b_q: got %h required cafef00d", b_q);
        end
        total++;
        if (b_cnt - b0 != 1) begin
            bad++;
            $display("FAIL steal_b_done: got %0d required 1", b_cnt - b0);
        end
    endtask

    task automatic test_init_gating;
        int b0, n;
        ctrl_init_done = 1'b0;
        do_reset;
        b0 = b_cnt;
        mdl_lat = 3;
        b_addr = 24'h000077;
        b_d = 32'h55555555;
        b_we = 1'b1;
        b_start = 1'b1;
        tick;
        b_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            total++;
            if ({ctrl_start, b_busy} !== 2'b01) begin
                bad++;
                $display("FAIL init_hold: start,busy got %b required 01", {ctrl_start, b_busy});
            end
            tick;
        end
        ctrl_init_done = 1'b1;
        tick;
        n = 1;
        while (ctrl_start !== 1'b1 && n < 6) begin
            tick;
            n++;
        end
        total++;
        if (n > 2 || b_busy !== 1'b1) begin
            bad++;
            $display("FAIL init_release: start after %0d cycles busy=%b required <=2 and 1",
                     n, b_busy);
        end
        wait_idle(50);
        total++;
        if (b_cnt - b0 != 1) begin
            bad++;
            $display("FAIL init_b_done: got %0d required 1", b_cnt - b0);
        end
    endtask

    task automatic test_reset_wait;
        int a0, i0, n;
        logic early;
        do_reset;
        a0 = a_cnt;
        mdl_lat = 12;
        mdl_rdata = 32'h0BADF00D;
        a_addr = 24'h000321;
        a_we = 1'b0;
        a_start = 1'b1;
        tick;
        a_start = 1'b0;
        n = 0;
        while (!ctrl_busy && n < 10) begin
            tick;
            n++;
        end
        mdl_lat = 3;
        tick;
        tick;
        reset = 1'b0;
        tick;
        total++;
        if ({ctrl_start, a_busy, a_done, b_busy} !== 4'b0) begin
            bad++;
            $display("FAIL rstw_flags: got %b required 0000", {ctrl_start, a_busy, a_done, b_busy});
        end
        total++;
        if (ctrl_addr !== '0 || ctrl_d !== '0) begin
            bad++;
            $display("FAIL rstw_ctrl_bus: got %h/%h required 0/0", ctrl_addr, ctrl_d);
        end
        i0 = n_issue;
        reset = 1'b1;
        a_addr = 24'h000789;
        a_start = 1'b1;
        tick;
        a_start = 1'b0;
        early = 1'b0;
        n = 0;
        while (ctrl_busy && n < 30) begin
            if (ctrl_start !== 1'b0)
                early = 1'b1;
            tick;
            n++;
        end
        total++;
        if (early !== 1'b0 || ctrl_busy) begin
            bad++;
            $display("FAIL rstw_start_while_busy: got early=%b busy=%b required 0/0",
                     early, ctrl_busy);
        end
        tick;
        total++;
        if (a_q !== '0 || a_cnt != a0) begin
            bad++;
            $display("FAIL rstw_orphan: a_q=%h dones=%0d required 0 and 0", a_q, a_cnt - a0);
        end
        wait_idle(50);
        total++;
        if (n_issue - i0 != 1 || iss_addr[i0 % 64] !== 24'h000789) begin
            bad++;
            $display("FAIL rstw_reissue: count=%0d addr=%h required 1 and 000789",
                     n_issue - i0, iss_addr[i0 % 64]);
        end
        total++;
        if (a_cnt - a0 != 1 || a_q !== 32'h0BADF00D) begin
            bad++;
            $display("FAIL rstw_done: dones=%0d a_q=%h required 1 and 0badf00d",
                     a_cnt - a0, a_q);
        end
    endtask

    task automatic test_ignored_strobe;
        int a0, i0;
        do_reset;
        a0 = a_cnt;
        i0 = n_issue;
        mdl_lat = 3;
        a_addr = 24'h0000AA;
        a_d = 32'h1;
        a_we = 1'b1;
        a_start = 1'b1;
        tick;
        a_addr = 24'h0000BB;
        a_d = 32'h2;
        tick;
        a_start = 1'b0;
        wait_idle(50);
        total++;
        if (n_issue - i0 != 1) begin
            bad++;
            $display("FAIL ign_issue_count: got %0d required 1", n_issue - i0);
        end
        total++;
        if (iss_addr[i0 % 64] !== 24'h0000AA) begin
            bad++;
            $display("FAIL ign_addr: got %h required 0000aa", iss_addr[i0 % 64]);
        end
        total++;
        if (a_cnt - a0 != 1) begin
            bad++;
            $display("FAIL ign_a_done: got %0d required 1", a_cnt - a0);
        end
    endtask

    initial begin
        tick;
        test_reset;
        test_single_read;
        test_rr_writes;
        test_refresh_steal;
        test_init_gating;
        test_reset_wait;
        test_ignored_strobe;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
